// File: rtl/lc3_mem_responder_if.sv
// Request/response bundle between the LC-3 core and the memory responder,
// plus the side-band preload port.
interface lc3_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] Instr_dout;
  logic              complete_instr;

  logic              Data_rd;
  logic              Data_wr;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              complete_data;

  logic              load_en;
  logic              load_sel;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  logic              instr_oob;
  logic              data_err;
  logic [31:0]       fetch_count;
  logic              fetch_limit_hit;

  modport slave (
    input  instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
           load_en, load_sel, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data,
           instr_oob, data_err, fetch_count, fetch_limit_hit
  );

  modport master (
    output instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
           load_en, load_sel, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data,
           instr_oob, data_err, fetch_count, fetch_limit_hit
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Instruction/data memory responder for the LC-3 pipeline with configurable
// wait states per channel, a preload port and fetch statistics.
//   state  | meaning
//   S_IDLE | channel free, a request is accepted on the next edge
//   S_WAIT | transaction in flight, counter counts wait states down to 1
module lc3_mem_responder #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 16,
  parameter int          IMEM_AW   = 8,
  parameter int          DMEM_AW   = 10,
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int          INSTR_LAT = 0,
  parameter int          DATA_LAT  = 2,
  parameter logic [31:0] MAX_FETCH = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic reset,
  lc3_mem_responder_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [3:0]        I_LAT = 4'(INSTR_LAT);
  localparam logic [3:0]        D_LAT = 4'(DATA_LAT);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  logic [DATA_W-1:0] imem [2**IMEM_AW];
  logic [DATA_W-1:0] dmem [2**DMEM_AW];

  state_e             i_state_q, i_state_d;
  logic [3:0]         i_cnt_q, i_cnt_d;
  logic [ADDR_W-1:0]  i_pc_q, i_pc_d;
  logic               i_fire;
  logic [ADDR_W-1:0]  i_op_pc, i_idx;
  logic               i_oob;

  state_e             d_state_q, d_state_d;
  logic [3:0]         d_cnt_q, d_cnt_d;
  logic [DMEM_AW-1:0] d_addr_q, d_addr_d;
  logic               d_wr_q, d_wr_d;
  logic [DATA_W-1:0]  d_din_q, d_din_d;
  logic               d_acc, d_fire, d_conflict;
  logic [DMEM_AW-1:0] d_op_addr;
  logic               d_op_wr;
  logic [DATA_W-1:0]  d_op_din;

  logic [DATA_W-1:0]  instr_dout_q, data_dout_q;
  logic               complete_instr_q, complete_data_q;
  logic               instr_oob_q, data_err_q, fetch_limit_q;
  logic [31:0]        fetch_count_q;

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_pc_d    = i_pc_q;
    i_fire    = 1'b0;
    case (i_state_q)
      S_IDLE: begin
        if (bus.instrmem_rd) begin
          i_pc_d = bus.pc;
          if (INSTR_LAT == 0) begin
            i_fire = 1'b1;
          end else begin
            i_state_d = S_WAIT;
            i_cnt_d   = I_LAT;
          end
        end
      end
      S_WAIT: begin
        if (i_cnt_q == 4'd1) begin
          i_fire = 1'b1;
          // A held request restarts immediately on the completing edge.
          if (bus.instrmem_rd) begin
            i_pc_d  = bus.pc;
            i_cnt_d = I_LAT;
          end else begin
            i_state_d = S_IDLE;
          end
        end else begin
          i_cnt_d = i_cnt_q - 4'd1;
        end
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  assign i_op_pc = (INSTR_LAT == 0) ? i_pc_d : i_pc_q;
  assign i_idx   = i_op_pc - BASE;
  assign i_oob   = |i_idx[ADDR_W-1:IMEM_AW];

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_addr_d  = d_addr_q;
    d_wr_d    = d_wr_q;
    d_din_d   = d_din_q;
    d_fire    = 1'b0;
    d_acc     = 1'b0;
    case (d_state_q)
      S_IDLE: d_acc = bus.Data_rd || bus.Data_wr;
      S_WAIT: begin
        if (d_cnt_q == 4'd1) begin
          d_fire    = 1'b1;
          d_acc     = bus.Data_rd || bus.Data_wr;
          d_state_d = S_IDLE;
        end else begin
          d_cnt_d = d_cnt_q - 4'd1;
        end
      end
      default: d_state_d = S_IDLE;
    endcase
    if (d_acc) begin
      d_addr_d = bus.Data_addr[DMEM_AW-1:0];
      d_wr_d   = bus.Data_wr && !bus.Data_rd;
      d_din_d  = bus.Data_din;
      if (DATA_LAT == 0) begin
        d_fire = 1'b1;
      end else begin
        d_state_d = S_WAIT;
        d_cnt_d   = D_LAT;
      end
    end
  end

  assign d_conflict = d_acc && bus.Data_rd && bus.Data_wr;
  assign d_op_addr  = (DATA_LAT == 0) ? d_addr_d : d_addr_q;
  assign d_op_wr    = (DATA_LAT == 0) ? d_wr_d   : d_wr_q;
  assign d_op_din   = (DATA_LAT == 0) ? d_din_d  : d_din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_state_q        <= S_IDLE;
      i_cnt_q          <= '0;
      i_pc_q           <= '0;
      d_state_q        <= S_IDLE;
      d_cnt_q          <= '0;
      d_addr_q         <= '0;
      d_wr_q           <= 1'b0;
      d_din_q          <= '0;
      instr_dout_q     <= '0;
      data_dout_q      <= '0;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      instr_oob_q      <= 1'b0;
      data_err_q       <= 1'b0;
      fetch_limit_q    <= 1'b0;
      fetch_count_q    <= '0;
    end else begin
      i_state_q        <= i_state_d;
      i_cnt_q          <= i_cnt_d;
      i_pc_q           <= i_pc_d;
      d_state_q        <= d_state_d;
      d_cnt_q          <= d_cnt_d;
      d_addr_q         <= d_addr_d;
      d_wr_q           <= d_wr_d;
      d_din_q          <= d_din_d;
      complete_instr_q <= i_fire;
      complete_data_q  <= d_fire;
      if (i_fire) begin
        instr_dout_q <= i_oob ? '0 : imem[i_idx[IMEM_AW-1:0]];
        if (i_oob) instr_oob_q <= 1'b1;
        if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (fetch_count_q >= MAX_FETCH) fetch_limit_q <= 1'b1;
      if (d_fire && !d_op_wr) data_dout_q <= dmem[d_op_addr];
      if (d_conflict) data_err_q <= 1'b1;
    end
  end

  // Preload is written last so it overrides a same-word channel write.
  always_ff @(posedge clk) begin
    if (!reset && d_fire && d_op_wr) dmem[d_op_addr] <= d_op_din;
    if (bus.load_en && bus.load_sel) dmem[bus.load_addr[DMEM_AW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (bus.load_en && !bus.load_sel) imem[bus.load_addr[IMEM_AW-1:0]] <= bus.load_data;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.Data_addr[ADDR_W-1:DMEM_AW], bus.load_addr[ADDR_W-1:DMEM_AW]};

  assign bus.Instr_dout      = instr_dout_q;
  assign bus.complete_instr  = complete_instr_q;
  assign bus.Data_dout       = data_dout_q;
  assign bus.complete_data   = complete_data_q;
  assign bus.instr_oob       = instr_oob_q;
  assign bus.data_err        = data_err_q;
  assign bus.fetch_count     = fetch_count_q;
  assign bus.fetch_limit_hit = fetch_limit_q;

endmodule
